// File: rtl/neural_stage_seq_pkg.sv
// Shared types and constants for the neural_stage sequencer.
package neural_stage_seq_pkg;

  // Packed float word used across the neural datapath: 24-bit mantissa, 8-bit exponent.
  typedef struct packed {
    logic [23:0] mant;
    logic [7:0]  expo;
  } float_24_8;

  // Default number of taps per neuron frame.
  localparam int NEURAL_NUM_TAPS = 16;

  // Sequencer control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/neural_stage_seq_delay_line.sv
// Fixed-depth shift register carrying a data word and a valid tag.
// clr_i drops every valid tag in flight (data words are left to shift out).
module neural_stage_seq_delay_line
  import neural_stage_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 18
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             vld_i,
  input  logic [WIDTH-1:0] d_i,
  output logic             vld_o,
  output logic [WIDTH-1:0] q_o
);

  logic [DEPTH-1:0][WIDTH-1:0] data_q;
  logic [DEPTH-1:0]            vld_q;

  // Advance every clock; the downstream stage is fixed-latency so stalls never hold this line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
      vld_q  <= '0;
    end else begin
      data_q[0] <= d_i;
      vld_q[0]  <= vld_i & ~clr_i;
      for (int i = 1; i < DEPTH; i++) begin
        data_q[i] <= data_q[i-1];
        vld_q[i]  <= vld_q[i-1] & ~clr_i;
      end
    end
  end

  assign q_o   = data_q[DEPTH-1];
  assign vld_o = vld_q[DEPTH-1];

endmodule

// File: rtl/neural_stage_seq.sv
// Sequencer feeding a neural_stage from a valid/ready sample stream.
// Emits each accepted sample with its tap index and frame-start flag one
// clock after acceptance, and the paired bias BIAS_DELAY clocks later so it
// lines up with the stage's fixed-latency accumulator.
module neural_stage_seq
  import neural_stage_seq_pkg::*;
#(
  parameter int NUM_TAPS    = NEURAL_NUM_TAPS,
  parameter int DATA_W      = $bits(float_24_8),
  parameter int BIAS_DELAY  = 18,
  parameter int NUM_SAMPLES = 65536,
  parameter int TAP_W       = $clog2(NUM_TAPS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] in_bias,
  output logic              stage_valid,
  output logic [DATA_W-1:0] stage_data,
  output logic [TAP_W-1:0]  tap_index,
  output logic              first,
  output logic [DATA_W-1:0] stage_bias,
  output logic              bias_valid,
  output logic [31:0]       sample_cnt,
  output logic              busy,
  output logic              done
);

  seq_state_t        state_q;
  logic              in_ready_q;
  logic              stage_valid_q;
  logic [DATA_W-1:0] stage_data_q;
  logic [DATA_W-1:0] bias_q;
  logic [TAP_W-1:0]  tap_index_q;
  logic              first_q;
  logic [TAP_W-1:0]  tap_q;
  logic [31:0]       sample_cnt_q;
  logic [31:0]       drain_q;
  logic              busy_q;
  logic              done_q;

  logic              accept_d;
  logic              last_d;
  logic [TAP_W-1:0]  tap_d;
  logic [31:0]       sample_cnt_d;

  // Tap counter wraps at NUM_TAPS, which need not be a power of two.
  function automatic logic [TAP_W-1:0] next_tap(input logic [TAP_W-1:0] t);
    return (t == TAP_W'(NUM_TAPS - 1)) ? '0 : t + TAP_W'(1);
  endfunction

  // Accepted-sample counter stops at NUM_SAMPLES instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (c >= 32'(NUM_SAMPLES)) ? c : c + 32'd1;
  endfunction

  // Handshake: abort suppresses an accept in the same cycle so abort always wins.
  always_comb begin
    accept_d     = in_valid & in_ready_q & ~abort;
    last_d       = accept_d & (sample_cnt_q == 32'(NUM_SAMPLES - 1));
    tap_d        = next_tap(tap_q);
    sample_cnt_d = sat_inc(sample_cnt_q);
  end

  // Control FSM with registered outputs; in_ready falls on the same edge that enters DRAIN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      in_ready_q    <= 1'b0;
      stage_valid_q <= 1'b0;
      stage_data_q  <= '0;
      bias_q        <= '0;
      tap_index_q   <= '0;
      first_q       <= 1'b0;
      tap_q         <= '0;
      sample_cnt_q  <= '0;
      drain_q       <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else if (abort) begin
      state_q       <= IDLE;
      in_ready_q    <= 1'b0;
      stage_valid_q <= 1'b0;
      first_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      stage_valid_q <= 1'b0;
      first_q       <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q      <= RUN;
            in_ready_q   <= 1'b1;
            tap_q        <= '0;
            sample_cnt_q <= '0;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
          end
        end
        RUN: begin
          if (accept_d) begin
            stage_valid_q <= 1'b1;
            stage_data_q  <= in_data;
            bias_q        <= in_bias;
            tap_index_q   <= tap_q;
            first_q       <= (tap_q == '0);
            tap_q         <= tap_d;
            sample_cnt_q  <= sample_cnt_d;
            if (last_d) begin
              state_q    <= DRAIN;
              in_ready_q <= 1'b0;
              drain_q    <= '0;
            end
          end
        end
        DRAIN: begin
          // BIAS_DELAY+1 clocks lets the final bias leave the delay line first.
          if (drain_q == 32'(BIAS_DELAY)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            drain_q <= drain_q + 32'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Bias is registered alongside stage_data, then delayed so it trails stage_valid by BIAS_DELAY.
  neural_stage_seq_delay_line #(
    .WIDTH (DATA_W),
    .DEPTH (BIAS_DELAY)
  ) u_bias_dly (
    .clk   (clk),
    .reset (reset),
    .clr_i (abort),
    .vld_i (stage_valid_q),
    .d_i   (bias_q),
    .vld_o (bias_valid),
    .q_o   (stage_bias)
  );

  assign in_ready    = in_ready_q;
  assign stage_valid = stage_valid_q;
  assign stage_data  = stage_data_q;
  assign tap_index   = tap_index_q;
  assign first       = first_q;
  assign sample_cnt  = sample_cnt_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_neural_stage_seq.sv
// Bench for neural_stage_seq: a 16-tap and a 12-tap instance share one
// stimulus stream; a scoreboard of expected stage and bias outputs is
// filled as samples are driven and drained as the DUTs respond.
module tb_neural_stage_seq;

  localparam int DW = 32;
  localparam int BD = 18;
  localparam int NS = 64;
  localparam int TW = 4;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DRAIN = 2;
  localparam int M_DONE  = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [DW-1:0] in_bias = '0;

  logic [1:0]          in_ready, sv, first, bv, busy, done;
  logic [1:0][DW-1:0]  sd, sb;
  logic [1:0][31:0]    scnt;
  logic [1:0][TW-1:0]  ti;

  typedef struct {
    int unsigned cyc;
    logic [31:0] data;
    int unsigned n;
  } sexp_t;

  typedef struct {
    int unsigned cyc;
    logic [31:0] val;
  } bexp_t;

  sexp_t sq[$];
  bexp_t bq[$];

  int unsigned cyc = 0;
  int          mstate = M_IDLE;
  int unsigned mn = 0;
  int unsigned mdrain = 0;
  int unsigned gk = 0;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  neural_stage_seq #(
    .NUM_TAPS(16), .DATA_W(DW), .BIAS_DELAY(BD), .NUM_SAMPLES(NS)
  ) dut16 (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready[0]), .in_data(in_data), .in_bias(in_bias),
    .stage_valid(sv[0]), .stage_data(sd[0]), .tap_index(ti[0]), .first(first[0]),
    .stage_bias(sb[0]), .bias_valid(bv[0]), .sample_cnt(scnt[0]),
    .busy(busy[0]), .done(done[0])
  );

  neural_stage_seq #(
    .NUM_TAPS(12), .DATA_W(DW), .BIAS_DELAY(BD), .NUM_SAMPLES(NS)
  ) dut12 (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready[1]), .in_data(in_data), .in_bias(in_bias),
    .stage_valid(sv[1]), .stage_data(sd[1]), .tap_index(ti[1]), .first(first[1]),
    .stage_bias(sb[1]), .bias_valid(bv[1]), .sample_cnt(scnt[1]),
    .busy(busy[1]), .done(done[1])
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic check_zero(input string pfx);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s.d%0d.stage_valid", pfx, d), 64'(sv[d]), 64'd0);
      chk($sformatf("%s.d%0d.stage_data", pfx, d), 64'(sd[d]), 64'd0);
      chk($sformatf("%s.d%0d.tap_index", pfx, d), 64'(ti[d]), 64'd0);
      chk($sformatf("%s.d%0d.first", pfx, d), 64'(first[d]), 64'd0);
      chk($sformatf("%s.d%0d.stage_bias", pfx, d), 64'(sb[d]), 64'd0);
      chk($sformatf("%s.d%0d.bias_valid", pfx, d), 64'(bv[d]), 64'd0);
      chk($sformatf("%s.d%0d.sample_cnt", pfx, d), 64'(scnt[d]), 64'd0);
      chk($sformatf("%s.d%0d.busy", pfx, d), 64'(busy[d]), 64'd0);
      chk($sformatf("%s.d%0d.done", pfx, d), 64'(done[d]), 64'd0);
      chk($sformatf("%s.d%0d.in_ready", pfx, d), 64'(in_ready[d]), 64'd0);
    end
  endtask

  // Compare every output of both DUTs against the model for the current cycle.
  task automatic monitor();
    logic        ev, evb;
    int unsigned taps, tap;
    ev  = (sq.size() > 0) && (sq[0].cyc == cyc);
    evb = (bq.size() > 0) && (bq[0].cyc == cyc);
    for (int d = 0; d < 2; d++) begin
      taps = (d == 0) ? 16 : 12;
      chk($sformatf("d%0d.stage_valid", d), 64'(sv[d]), 64'(ev));
      if (ev) begin
        tap = sq[0].n % taps;
        chk($sformatf("d%0d.stage_data", d), 64'(sd[d]), 64'(sq[0].data));
        chk($sformatf("d%0d.tap_index", d), 64'(ti[d]), 64'(tap));
        chk($sformatf("d%0d.first", d), 64'(first[d]), 64'(tap == 0));
      end else begin
        chk($sformatf("d%0d.first_idle", d), 64'(first[d]), 64'd0);
      end
      chk($sformatf("d%0d.in_ready", d), 64'(in_ready[d]), 64'(mstate == M_RUN));
      chk($sformatf("d%0d.busy", d), 64'(busy[d]), 64'(mstate == M_RUN || mstate == M_DRAIN));
      chk($sformatf("d%0d.done", d), 64'(done[d]), 64'(mstate == M_DONE));
      chk($sformatf("d%0d.sample_cnt", d), 64'(scnt[d]), 64'(mn));
      chk($sformatf("d%0d.bias_valid", d), 64'(bv[d]), 64'(evb));
      if (evb) chk($sformatf("d%0d.stage_bias", d), 64'(sb[d]), 64'(bq[0].val));
    end
    if (ev)  void'(sq.pop_front());
    if (evb) void'(bq.pop_front());
  endtask

  // One clock: check outputs, then drive inputs for the next edge and advance the model.
  task automatic step(input logic st, input logic ab, input logic v);
    sexp_t se;
    bexp_t be;
    @(negedge clk);
    monitor();
    start    = st;
    abort    = ab;
    in_valid = v;
    in_data  = v ? (32'hA500_0000 | 32'(gk)) : 32'($urandom);
    in_bias  = v ? 32'(gk) : 32'($urandom);
    if (ab) begin
      mstate = M_IDLE;
      bq.delete();
    end else begin
      case (mstate)
        M_IDLE, M_DONE: if (st) begin
          mstate = M_RUN;
          mn     = 0;
        end
        M_RUN: if (v) begin
          se.cyc = cyc + 1; se.data = in_data; se.n = mn;
          sq.push_back(se);
          be.cyc = cyc + 1 + BD; be.val = in_bias;
          bq.push_back(be);
          mn++;
          gk++;
          if (mn == NS) begin
            mstate = M_DRAIN;
            mdrain = 0;
          end
        end
        M_DRAIN: begin
          mdrain++;
          if (mdrain == BD + 1) mstate = M_DONE;
        end
        default: mstate = M_IDLE;
      endcase
    end
  endtask

  initial begin
    // Power-on reset
    #2 reset = 1'b1;
    #10 check_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    // Run A: continuous stream, valid held through drain
    step(1'b1, 1'b0, 1'b0);
    repeat (NS + BD + 4) step(1'b0, 1'b0, 1'b1);
    chk("A.done", 64'(done[0]), 64'd1);
    chk("A.sample_cnt", 64'(scnt[0]), 64'(NS));

    // Run B: restart from DONE, 5-cycle stall at tap 7, stray start mid-run
    step(1'b1, 1'b0, 1'b0);
    repeat (7) step(1'b0, 1'b0, 1'b1);
    repeat (5) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    repeat (56 + BD + 4) step(1'b0, 1'b0, 1'b1);
    chk("B.done", 64'(done[1]), 64'd1);

    // Run C: abort coincident with the final accept
    step(1'b1, 1'b0, 1'b0);
    repeat (NS - 1) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    chk("C.bias_valid_after_abort", 64'(bv[0]), 64'd0);
    repeat (BD + 6) step(1'b0, 1'b0, 1'b1);
    chk("C.no_done", 64'(done[0]), 64'd0);

    // Run D: async reset between clock edges mid-run
    step(1'b1, 1'b0, 1'b0);
    repeat (10) step(1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1 check_zero("async_reset");
    mstate = M_IDLE;
    mn     = 0;
    sq.delete();
    bq.delete();
    @(negedge clk);
    start    = 1'b0;
    abort    = 1'b0;
    in_valid = 1'b0;
    reset    = 1'b0;

    // Run E: clean run after reset with random valid gaps
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 800 && mstate != M_DONE; i++)
      step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
    step(1'b0, 1'b0, 1'b0);
    chk("E.reached_done", 64'(done[0]), 64'd1);
    repeat (3) step(1'b0, 1'b0, 1'b0);

    chk("stage_queue_empty", 64'(sq.size()), 64'd0);
    chk("bias_queue_empty", 64'(bq.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/neural_stage_seq.md
Name: neural_stage_seq

Overview:
Synthesizable sequencer that feeds a neural_stage pipeline from a valid/ready sample stream. Per sample it generates:
- the tap index and the frame-start strobe (first);
- the bias, delayed to line up with the stage's fixed-latency accumulator.

It is parametrised in tap count, data width, bias alignment and run length. It adds stall handling, drain, done and abort behaviour, none of which the fixed free-running counter sequencing has. It sits between the sample/bias source (memory reader or upstream layer) and neural_stage.

Parameters:
- NUM_TAPS, 16, taps per neuron frame; any value >= 2, not restricted to a power of two.
- DATA_W, 32, width of data and bias words (float_24_8 packed = 32).
- BIAS_DELAY, 18, clocks between stage_data of a sample and stage_bias of the same sample; >= 1.
- NUM_SAMPLES, 65536, samples per run; >= 1.
- TAP_W, $clog2(NUM_TAPS), tap index width (derived).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a run from IDLE
- abort  in  1  one-cycle pulse; returns to IDLE from any state
- in_valid  in  1  upstream sample valid
- in_ready  out  1  sequencer accepts sample
- in_data  in  DATA_W  sample word
- in_bias  in  DATA_W  bias word paired with the sample
- stage_valid  out  1  stage_data/tap_index/first valid this cycle
- stage_data  out  DATA_W  sample to neural_stage
- tap_index  out  TAP_W  tap select for this sample
- first  out  1  frame start (tap_index==0 and stage_valid)
- stage_bias  out  DATA_W  delayed bias
- bias_valid  out  1  stage_bias valid
- sample_cnt  out  32  samples accepted this run
- busy  out  1  state is RUN or DRAIN
- done  out  1  high in DONE

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE.
  - All outputs and the delay line are 0.
  - in_ready is 0.
- States are IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start -> RUN.
  - sample_cnt and the tap counter clear on entry to RUN.
- RUN:
  - in_ready = 1.
  - Accept when in_valid && in_ready.
  - The cycle after an accept: stage_valid=1, stage_data=in_data, tap_index=current tap counter, first=(tap counter==0).
  - The tap counter wraps from NUM_TAPS-1 to 0.
  - sample_cnt increments per accept.
  - No accept in a cycle: stage_valid=0 next cycle. first=0, stage_data holds, tap counter holds; partial frames resume mid-frame.
- Accepting the NUM_SAMPLES-th sample -> DRAIN. in_ready drops the same cycle the transition registers, so no extra accept is possible.
- DRAIN:
  - in_ready=0.
  - A drain counter runs BIAS_DELAY+1 cycles, then the state goes to DONE.
- DONE:
  - done=1, busy=0.
  - start -> RUN, a new run with counters cleared.
- Bias path:
  - in_bias is captured on accept with a valid tag into a BIAS_DELAY-deep shift register.
  - The register advances every clock, independent of stalls, because neural_stage is fixed-latency.
  - The same sample's stage_bias/bias_valid appear exactly BIAS_DELAY cycles after its stage_valid.
- abort:
  - Forces IDLE next cycle from any state.
  - Clears the delay line valids and sets stage_valid=0, in_ready=0.
  - abort coincident with start or with the final accept: abort wins.
- start outside IDLE/DONE is ignored.
- sample_cnt saturates at NUM_SAMPLES; it never wraps.

Decomposition:
- Shared package holds:
  - the float_24_8 typedef (already present);
  - the NEURAL_NUM_TAPS default constant;
  - the seq_state_t enum (IDLE, RUN, DRAIN, DONE).
- One sub-module, delay_line: parametrised WIDTH/DEPTH shift register carrying a valid bit, with a synchronous clear input for abort. It is instantiated for the bias path.

Test Plan:
- Reset, start, in_valid held high, NUM_TAPS=16, NUM_SAMPLES=64 -> required response:
  - first on stage cycles 0, 16, 32, 48;
  - tap_index 0..15 repeating;
  - sample_cnt=64;
  - done asserted BIAS_DELAY+1 cycles after the last accept.
- Bias alignment: in_bias = sample number, BIAS_DELAY=18 -> stage_bias==k exactly 18 cycles after stage_data==k, for every k.
- Stall: in_valid low for 5 cycles at tap 7 -> stage_valid low for 5 cycles, tap_index resumes at 7, first not reasserted.
- NUM_TAPS=12 (non power of two) -> tap_index wraps from 11 to 0, first every 12 accepts.
- abort on the same cycle as the final accept (sample 63) -> IDLE, done never asserted, bias_valid low next cycle.
- Async reset asserted mid-RUN between clock edges -> all outputs 0 immediately; later start -> clean run beginning at tap 0.
